grid_encoder: RTL and testbench
===============================

GRID_ENCODER -- requirements
Module: grid_encoder

Interface
REQ-001 Parameter ON_CODE, default 2'b01, 2-bit cell code emitted for a set bit (bit 0 of the code = low bit of the cell pair).
REQ-002 Parameter OFF_CODE, default 2'b00, 2-bit cell code emitted for a clear bit.
REQ-003 clk_in  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n_in  input  1  asynchronous, active-low reset.
REQ-005 start_in  input  1  request to encode the current row inputs; level-sampled.
REQ-006 row1 .. row10  input  10 each  binary grid rows; bit i = cell i of that row.
REQ-007 row1_out .. row10_out  output  20 each  encoded rows; bits [2i+1:2i] = code for cell i.
REQ-008 busy  output  1  high while a job is captured and not yet delivered.
REQ-009 done  output  1  one-cycle pulse marking that new row*_out values are valid.

Function
REQ-010 FSM states: IDLE, ENCODE, OUTPUT.
REQ-011 IDLE, start_in=1 at edge T: capture all ten rows into internal registers, clear internal 20-bit accumulators to 0, cell index i=0, go to ENCODE.
REQ-012 IDLE, start_in=0: remain IDLE; outputs hold.
REQ-013 ENCODE: one cell per edge, at edges T+1..T+10 for i=0..9; for every row r, accumulator_r[2i+1:2i] = ON_CODE if captured row_r[i]=1, else OFF_CODE; i increments by 1.
REQ-014 Index i is 4 bits; at edge T+10 (i=9), go to OUTPUT; i never exceeds 9 and never wraps into a second pass.
REQ-015 OUTPUT, edge T+11: copy all ten accumulators to row*_out, assert done for exactly the following cycle, return to IDLE.
REQ-016 Latency: start sampled at edge T gives done=1 and valid outputs in the cycle after edge T+11, i.e. 11 cycles after capture.
REQ-017 busy = 1 in ENCODE and OUTPUT, 0 in IDLE; busy falls in the same cycle done rises.
REQ-018 start_in is ignored while busy=1; no re-capture, no restart, no queuing.
REQ-019 start_in=1 during the done cycle (state IDLE) is accepted: a new job starts back-to-back, and done from the prior job still pulses normally.
REQ-020 Row inputs may change freely after capture; results depend only on values captured at edge T.
REQ-021 row*_out change only at the OUTPUT edge; they hold the last job's values otherwise, including throughout the next job.
REQ-022 Round-trip: with default parameters, any value of the ten 20-bit outputs, decoded by the team's row translator (cell = 1 iff code == 2'b01), reproduces the ten original 10-bit rows exactly.
REQ-023 If ON_CODE == OFF_CODE, encoding proceeds unchanged; no error is flagged.

Reset
REQ-024 While reset_n_in=0, immediately and independent of clk_in: state=IDLE, i=0, all captured rows and accumulators=0, row*_out=0, busy=0, done=0.
REQ-025 Reset asserted mid-ENCODE or mid-OUTPUT aborts the job; no done pulse for it, and row*_out stay 0 after release.
REQ-026 After reset_n_in rises, the first rising edge with start_in=1 starts a job per REQ-011.

Verification
REQ-027 Reset then row1=10'h3FF, others 0, start 1 cycle -> after 11 cycles: done pulse, row1_out=20'h55555, others 20'h00000, busy high exactly 11 cycles.
REQ-028 row5=10'b0000000001, row10=10'b1000000000 -> row5_out=20'h00001, row10_out=20'h40000.
REQ-029 Start accepted, then rows changed and start re-pulsed at cycle 3 -> single done at cycle 11, outputs match first-captured rows only.
REQ-030 start held high continuously -> done every 12 cycles, busy low only in each done cycle, second result reflects rows present at the done cycle.
REQ-031 reset_n_in pulsed low at cycle 5 of a job -> no done, all outputs 0; a new job after release completes normally.
REQ-032 Random rows x 1000 jobs, outputs fed through the row translator -> decoded rows equal stimulus rows.

Source files
------------

// File: rtl/grid_encoder.sv
// Ten-row grid encoder: captures ten 10-bit rows, expands each cell into a
// 2-bit code one column per clock, then publishes all ten 20-bit rows at once.
module grid_encoder #(
    parameter logic [1:0] ON_CODE  = 2'b01,
    parameter logic [1:0] OFF_CODE = 2'b00
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        start_in,
    input  logic [9:0]  row1,
    input  logic [9:0]  row2,
    input  logic [9:0]  row3,
    input  logic [9:0]  row4,
    input  logic [9:0]  row5,
    input  logic [9:0]  row6,
    input  logic [9:0]  row7,
    input  logic [9:0]  row8,
    input  logic [9:0]  row9,
    input  logic [9:0]  row10,
    output logic [19:0] row1_out,
    output logic [19:0] row2_out,
    output logic [19:0] row3_out,
    output logic [19:0] row4_out,
    output logic [19:0] row5_out,
    output logic [19:0] row6_out,
    output logic [19:0] row7_out,
    output logic [19:0] row8_out,
    output logic [19:0] row9_out,
    output logic [19:0] row10_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENCODE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [3:0]  idx_r;
    logic [9:0]  rows_s [10];
    logic [9:0]  cap_r  [10];
    logic [19:0] acc_r  [10];
    logic [19:0] out_r  [10];
    logic        busy_r;
    logic        done_r;

    assign rows_s[0] = row1;
    assign rows_s[1] = row2;
    assign rows_s[2] = row3;
    assign rows_s[3] = row4;
    assign rows_s[4] = row5;
    assign rows_s[5] = row6;
    assign rows_s[6] = row7;
    assign rows_s[7] = row8;
    assign rows_s[8] = row9;
    assign rows_s[9] = row10;

    assign row1_out  = out_r[0];
    assign row2_out  = out_r[1];
    assign row3_out  = out_r[2];
    assign row4_out  = out_r[3];
    assign row5_out  = out_r[4];
    assign row6_out  = out_r[5];
    assign row7_out  = out_r[6];
    assign row8_out  = out_r[7];
    assign row9_out  = out_r[8];
    assign row10_out = out_r[9];
    assign busy      = busy_r;
    assign done      = done_r;

    // State register.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; start is only honoured from IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_in) begin
                    next_state_s = ENCODE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ENCODE: begin
                if (idx_r == 4'd9) begin
                    next_state_s = OUTPUT;
                end else begin
                    next_state_s = ENCODE;
                end
            end
            OUTPUT:  next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Capture, per-column encode and publish datapath.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            idx_r  <= 4'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            for (int r = 0; r < 10; r++) begin
                cap_r[r] <= 10'd0;
                acc_r[r] <= 20'd0;
                out_r[r] <= 20'd0;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_in) begin
                        idx_r  <= 4'd0;
                        busy_r <= 1'b1;
                        for (int r = 0; r < 10; r++) begin
                            cap_r[r] <= rows_s[r];
                            acc_r[r] <= 20'd0;
                        end
                    end
                end
                ENCODE: begin
                    for (int r = 0; r < 10; r++) begin
                        acc_r[r][{idx_r, 1'b0} +: 2] <= cap_r[r][idx_r] ? ON_CODE : OFF_CODE;
                    end
                    // Index parks at the last column instead of wrapping.
                    idx_r <= (idx_r == 4'd9) ? idx_r : idx_r + 4'd1;
                end
                OUTPUT: begin
                    for (int r = 0; r < 10; r++) begin
                        out_r[r] <= acc_r[r];
                    end
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_encoder.sv
// Randomized self-checking bench for grid_encoder against an arithmetic
// reference encoder/decoder; all sampling and driving happens on the falling edge.
module tb_grid_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [9:0]  rows [10];
    logic [19:0] o    [10];
    logic [19:0] o2   [10];
    logic        busy, done, busy2, done2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    grid_encoder dut (
        .clk_in(clk), .reset_n_in(reset_n), .start_in(start),
        .row1(rows[0]), .row2(rows[1]), .row3(rows[2]), .row4(rows[3]), .row5(rows[4]),
        .row6(rows[5]), .row7(rows[6]), .row8(rows[7]), .row9(rows[8]), .row10(rows[9]),
        .row1_out(o[0]), .row2_out(o[1]), .row3_out(o[2]), .row4_out(o[3]), .row5_out(o[4]),
        .row6_out(o[5]), .row7_out(o[6]), .row8_out(o[7]), .row9_out(o[8]), .row10_out(o[9]),
        .busy(busy), .done(done)
    );

    grid_encoder #(.ON_CODE(2'b10), .OFF_CODE(2'b11)) dut_alt (
        .clk_in(clk), .reset_n_in(reset_n), .start_in(start),
        .row1(rows[0]), .row2(rows[1]), .row3(rows[2]), .row4(rows[3]), .row5(rows[4]),
        .row6(rows[5]), .row7(rows[6]), .row8(rows[7]), .row9(rows[8]), .row10(rows[9]),
        .row1_out(o2[0]), .row2_out(o2[1]), .row3_out(o2[2]), .row4_out(o2[3]), .row5_out(o2[4]),
        .row6_out(o2[5]), .row7_out(o2[6]), .row8_out(o2[7]), .row9_out(o2[8]), .row10_out(o2[9]),
        .busy(busy2), .done(done2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: each cell contributes code * 4^i.
    function automatic logic [19:0] ref_encode(input logic [9:0] row, input int on_c, input int off_c);
        int val = 0;
        for (int i = 0; i < 10; i++) begin
            val += (row[i] ? on_c : off_c) * (4 ** i);
        end
        return val[19:0];
    endfunction

    // Row translator: a cell is set iff its code equals 1.
    function automatic logic [9:0] ref_decode(input logic [19:0] enc);
        int v = int'(enc);
        int res = 0;
        for (int i = 0; i < 10; i++) begin
            if (((v / (4 ** i)) % 4) == 1) res += 2 ** i;
        end
        return res[9:0];
    endfunction

    task automatic check_outputs(input logic [9:0] r [10]);
        for (int i = 0; i < 10; i++) begin
            check_val($sformatf("row%0d_out", i + 1), {12'd0, o[i]}, {12'd0, ref_encode(r[i], 1, 0)});
            check_val($sformatf("alt_row%0d_out", i + 1), {12'd0, o2[i]}, {12'd0, ref_encode(r[i], 2, 3)});
            check_val($sformatf("decode_row%0d", i + 1), {22'd0, ref_decode(o[i])}, {22'd0, r[i]});
        end
    endtask

    // Launch one job from the current falling edge and follow it to done.
    task automatic run_job(input logic [9:0] r [10], input bit repulse);
        int  k;
        int  bcnt = 0;
        bit  seen = 1'b0;
        for (int i = 0; i < 10; i++) rows[i] = r[i];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (k = 1; k <= 20; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bcnt++;
            for (int i = 0; i < 10; i++) rows[i] = 10'($urandom);
            start = (repulse && k == 3) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check_val("done_seen", {31'd0, seen}, 32'd1);
        check_val("latency", k, 32'd12);
        check_val("busy_cycles", bcnt, 32'd11);
        check_val("busy_in_done", {31'd0, busy}, 32'd0);
        check_val("alt_done", {31'd0, done2}, 32'd1);
        check_val("alt_busy", {31'd0, busy2}, 32'd0);
        check_outputs(r);
    endtask

    logic [9:0] ra [10];
    logic [9:0] rb [10];
    int         dcnt;
    int         k2;
    int         lows;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < 10; i++) rows[i] = 10'd0;
        #12;
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        check_val("reset_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 10; i++) check_val("reset_out", {12'd0, o[i]}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single full row.
        for (int i = 0; i < 10; i++) ra[i] = 10'd0;
        ra[0] = 10'h3FF;
        run_job(ra, 1'b0);
        check_val("full_row1", {12'd0, o[0]}, 32'h55555);
        check_val("full_row2", {12'd0, o[1]}, 32'h00000);

        // Corner cells, started back-to-back in the done cycle.
        for (int i = 0; i < 10; i++) ra[i] = 10'd0;
        ra[4] = 10'b0000000001;
        ra[9] = 10'b1000000000;
        run_job(ra, 1'b0);
        check_val("corner_row5", {12'd0, o[4]}, 32'h00001);
        check_val("corner_row10", {12'd0, o[9]}, 32'h40000);

        // Re-pulsed start while busy is ignored.
        for (int i = 0; i < 10; i++) ra[i] = 10'($urandom);
        @(negedge clk);
        run_job(ra, 1'b1);
        dcnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check_val("no_second_done", dcnt, 32'd0);
        check_outputs(ra);

        // Start held high: one job per 12 cycles, second captures rows at the done cycle.
        for (int i = 0; i < 10; i++) begin
            ra[i] = 10'($urandom);
            rb[i] = 10'($urandom);
            rows[i] = ra[i];
        end
        start = 1'b1;
        for (k2 = 0; k2 < 20 && !done; k2++) @(negedge clk);
        check_val("cont_done1", {31'd0, done}, 32'd1);
        check_val("cont_busy1", {31'd0, busy}, 32'd0);
        check_outputs(ra);
        for (int i = 0; i < 10; i++) rows[i] = rb[i];
        lows = 0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) rows[i] = 10'($urandom);
        for (k2 = 1; k2 <= 20 && !done; k2++) begin
            if (!busy) lows++;
            @(negedge clk);
        end
        start = 1'b0;
        check_val("cont_period", k2, 32'd12);
        check_val("cont_busy_lows", lows, 32'd0);
        check_outputs(rb);

        // Reset in the middle of a job.
        @(negedge clk);
        for (int i = 0; i < 10; i++) rows[i] = 10'($urandom) | 10'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 10; i++) check_val("abort_out", {12'd0, o[i]}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check_val("abort_no_activity", dcnt, 32'd0);
        for (int i = 0; i < 10; i++) check_val("abort_out_after", {12'd0, o[i]}, 32'd0);

        // Random jobs, occasionally with idle gaps between them.
        for (int j = 0; j < 1000; j++) begin
            for (int i = 0; i < 10; i++) ra[i] = 10'($urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_job(ra, $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
